// File: rtl/bsg_dfi_to_fifo_packer.sv
// DFI-to-FIFO bridge for the DRAM controller side of the DMC path.
// Packs clk_ratio_p DFI write beats into one wide word, buffers packed write
// words and DFI commands in els_p-deep FIFOs, unpacks wide read words into
// per-cycle DFI read beats after rd_latency_p cycles, and keeps sticky
// overflow/underrun flags.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   dfi_*_i                   DFI command, write and read-enable inputs
//   dfi_rddata_o/_valid_o     unpacked read beat and its valid
//   fifo_wr_*                 packed write word stream (valid/ready)
//   fifo_cmd_*                command stream (valid/ready)
//   fifo_rd_v_i/_data_i/_yumi_o  wide read word source
//   error_clear_i, fifo_error_o  sticky {rd underrun, cmd overflow, wr overflow}
module bsg_dfi_to_fifo_packer #(
  parameter int unsigned dq_data_width_p = 32,
  parameter int unsigned clk_ratio_p     = 2,
  parameter int unsigned els_p           = 4,
  parameter int unsigned rd_latency_p    = 2,
  localparam int unsigned dq_group_lp = dq_data_width_p / 8,
  localparam int unsigned beat_w_lp   = 2*dq_data_width_p + 2*dq_group_lp,
  localparam int unsigned word_w_lp   = clk_ratio_p * beat_w_lp,
  localparam int unsigned rbeat_w_lp  = 2*dq_data_width_p,
  localparam int unsigned rword_w_lp  = clk_ratio_p * rbeat_w_lp,
  localparam int unsigned cmd_w_lp    = 26
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [2:0]               dfi_bank_i,
  input  logic [15:0]              dfi_address_i,
  input  logic                     dfi_cke_i,
  input  logic                     dfi_cs_n_i,
  input  logic                     dfi_ras_n_i,
  input  logic                     dfi_cas_n_i,
  input  logic                     dfi_we_n_i,
  input  logic                     dfi_reset_n_i,
  input  logic                     dfi_odt_i,
  input  logic                     dfi_wrdata_en_i,
  input  logic [rbeat_w_lp-1:0]    dfi_wrdata_i,
  input  logic [2*dq_group_lp-1:0] dfi_wrdata_mask_i,
  input  logic                     dfi_rddata_en_i,
  output logic [rbeat_w_lp-1:0]    dfi_rddata_o,
  output logic                     dfi_rddata_valid_o,
  output logic                     fifo_wr_v_o,
  output logic [word_w_lp-1:0]     fifo_wr_data_o,
  input  logic                     fifo_wr_ready_i,
  output logic                     fifo_cmd_v_o,
  output logic [cmd_w_lp-1:0]      fifo_cmd_data_o,
  input  logic                     fifo_cmd_ready_i,
  input  logic                     fifo_rd_v_i,
  input  logic [rword_w_lp-1:0]    fifo_rd_data_i,
  output logic                     fifo_rd_yumi_o,
  input  logic                     error_clear_i,
  output logic [2:0]               fifo_error_o
);

  localparam int unsigned cnt_w_lp = (clk_ratio_p > 1) ? $clog2(clk_ratio_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(clk_ratio_p - 1);

  logic [cnt_w_lp-1:0]     wr_cnt_q, wr_cnt_d;
  logic [word_w_lp-1:0]    wr_buf_q, wr_buf_d;
  logic                    wr_enq_c;
  logic                    wr_drop_c, cmd_drop_c;
  logic [rd_latency_p-1:0] rd_pipe_q, rd_pipe_d;
  logic [cnt_w_lp-1:0]     rd_cnt_q, rd_cnt_d;
  logic [2:0]              err_q, err_d;
  logic                    rd_valid_c;

  // Write packer: slot the beat at wr_cnt; the last beat completes the word
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_buf_d = wr_buf_q;
    wr_enq_c = 1'b0;
    if (dfi_wrdata_en_i) begin
      wr_buf_d[wr_cnt_q*beat_w_lp +: beat_w_lp] = {dfi_wrdata_i, dfi_wrdata_mask_i};
      if (wr_cnt_q == cnt_last_lp) begin
        wr_cnt_d = '0;
        wr_enq_c = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + cnt_w_lp'(1);
      end
    end
  end

  // Packed write words; wr_buf_d already carries the completing beat
  bsg_dfi_to_fifo_packer_fifo #(.width_p(word_w_lp), .els_p(els_p)) wr_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (wr_enq_c),
    .data_i  (wr_buf_d),
    .drop_o  (wr_drop_c),
    .v_o     (fifo_wr_v_o),
    .data_o  (fifo_wr_data_o),
    .ready_i (fifo_wr_ready_i)
  );

  // Command FIFO: one entry per chip-selected cycle
  bsg_dfi_to_fifo_packer_fifo #(.width_p(cmd_w_lp), .els_p(els_p)) cmd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (~dfi_cs_n_i),
    .data_i  ({dfi_bank_i, dfi_address_i, dfi_cke_i, dfi_cs_n_i, dfi_ras_n_i,
               dfi_cas_n_i, dfi_we_n_i, dfi_reset_n_i, dfi_odt_i}),
    .drop_o  (cmd_drop_c),
    .v_o     (fifo_cmd_v_o),
    .data_o  (fifo_cmd_data_o),
    .ready_i (fifo_cmd_ready_i)
  );

  assign rd_valid_c = rd_pipe_q[rd_latency_p-1];

  // Read path: latency shift register, beat counter, unpack mux
  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = dfi_rddata_en_i;
    rd_cnt_d     = rd_cnt_q;
    if (rd_valid_c) begin
      rd_cnt_d = (rd_cnt_q == cnt_last_lp) ? '0 : rd_cnt_q + cnt_w_lp'(1);
    end
    dfi_rddata_o = '0;
    if (rd_valid_c && fifo_rd_v_i) begin
      dfi_rddata_o = fifo_rd_data_i[rd_cnt_q*rbeat_w_lp +: rbeat_w_lp];
    end
  end

  assign dfi_rddata_valid_o = rd_valid_c;
  assign fifo_rd_yumi_o     = rd_valid_c & fifo_rd_v_i & (rd_cnt_q == cnt_last_lp);

  // Sticky errors; a new error in the clearing cycle survives the clear
  always_comb begin
    err_d = error_clear_i ? 3'b000 : err_q;
    err_d = err_d | {rd_valid_c & ~fifo_rd_v_i, cmd_drop_c, wr_drop_c};
  end

  assign fifo_error_o = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_cnt_q  <= '0;
      wr_buf_q  <= '0;
      rd_pipe_q <= '0;
      rd_cnt_q  <= '0;
      err_q     <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_buf_q  <= wr_buf_d;
      rd_pipe_q <= rd_pipe_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// Circular FIFO: full is judged before the same-cycle dequeue; data_o is
// zero while empty so the outputs read 0 out of reset.
module bsg_dfi_to_fifo_packer_fifo #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  output logic               drop_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [ptr_w_lp:0]   cnt_q, cnt_d;
  logic                full_c, enq_ok_c, deq_c;

  assign full_c   = (cnt_q == (ptr_w_lp+1)'(els_p));
  assign enq_ok_c = enq_i & ~full_c;
  assign deq_c    = v_o & ready_i;
  assign drop_o   = enq_i & full_c;
  assign v_o      = (cnt_q != '0);
  assign data_o   = v_o ? mem_q[rptr_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (enq_ok_c && !deq_c) cnt_d = cnt_q + (ptr_w_lp+1)'(1);
    else if (!enq_ok_c && deq_c) cnt_d = cnt_q - (ptr_w_lp+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq_ok_c) wptr_q <= wptr_q + ptr_w_lp'(1);
      if (deq_c)    rptr_q <= rptr_q + ptr_w_lp'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; contents are only visible while occupied
  always_ff @(posedge clk_i) begin
    if (enq_ok_c) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: tb/tb_bsg_dfi_to_fifo_packer.sv
module tb_bsg_dfi_to_fifo_packer;

  localparam int unsigned DQ  = 32;
  localparam int unsigned R   = 2;
  localparam int unsigned ELS = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned GRP = DQ / 8;
  localparam int unsigned BW  = 2*DQ + 2*GRP;
  localparam int unsigned WW  = R * BW;
  localparam int unsigned RBW = 2*DQ;
  localparam int unsigned RWW = R * RBW;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic [2:0]       bank = '0;
  logic [15:0]      addr = '0;
  logic             cs_n = 1'b1;
  logic             wr_en = 1'b0;
  logic [RBW-1:0]   wr_data = '0;
  logic [2*GRP-1:0] wr_mask = '0;
  logic             rd_en = 1'b0;
  logic [RBW-1:0]   dfi_rddata_o;
  logic             dfi_rddata_valid_o;
  logic             fifo_wr_v_o;
  logic [WW-1:0]    fifo_wr_data_o;
  logic             wr_ready = 1'b1;
  logic             fifo_cmd_v_o;
  logic [25:0]      fifo_cmd_data_o;
  logic             cmd_ready = 1'b1;
  logic             rd_v = 1'b0;
  logic [RWW-1:0]   rd_data = '0;
  logic             fifo_rd_yumi_o;
  logic             err_clr = 1'b0;
  logic [2:0]       fifo_error_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0]  d0;
    logic [7:0]   m0;
    logic [63:0]  d1;
    logic [7:0]   m1;
    logic [143:0] exp;
  } wr_vec_t;

  typedef struct {
    logic [127:0] data;
    logic [63:0]  e0;
    logic [63:0]  e1;
  } rd_vec_t;

  typedef struct {
    logic [63:0] d;
    logic        y;
  } rd_exp_t;

  logic [WW-1:0] wq [$];
  logic [25:0]   cq [$];
  rd_exp_t       rq [$];

  always #5 clk = ~clk;

  bsg_dfi_to_fifo_packer #(
    .dq_data_width_p(DQ), .clk_ratio_p(R), .els_p(ELS), .rd_latency_p(LAT)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .dfi_bank_i         (bank),
    .dfi_address_i      (addr),
    .dfi_cke_i          (1'b1),
    .dfi_cs_n_i         (cs_n),
    .dfi_ras_n_i        (1'b0),
    .dfi_cas_n_i        (1'b1),
    .dfi_we_n_i         (1'b1),
    .dfi_reset_n_i      (1'b1),
    .dfi_odt_i          (1'b0),
    .dfi_wrdata_en_i    (wr_en),
    .dfi_wrdata_i       (wr_data),
    .dfi_wrdata_mask_i  (wr_mask),
    .dfi_rddata_en_i    (rd_en),
    .dfi_rddata_o       (dfi_rddata_o),
    .dfi_rddata_valid_o (dfi_rddata_valid_o),
    .fifo_wr_v_o        (fifo_wr_v_o),
    .fifo_wr_data_o     (fifo_wr_data_o),
    .fifo_wr_ready_i    (wr_ready),
    .fifo_cmd_v_o       (fifo_cmd_v_o),
    .fifo_cmd_data_o    (fifo_cmd_data_o),
    .fifo_cmd_ready_i   (cmd_ready),
    .fifo_rd_v_i        (rd_v),
    .fifo_rd_data_i     (rd_data),
    .fifo_rd_yumi_o     (fifo_rd_yumi_o),
    .error_clear_i      (err_clr),
    .fifo_error_o       (fifo_error_o)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Command layout with the fixed control levels driven above
  function automatic logic [25:0] exp_cmd(input logic [2:0] b, input logic [15:0] a);
    return {b, a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic wr_beat(input logic [63:0] d, input logic [7:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wr_burst(input logic [63:0] d0, input logic [7:0] m0,
                          input logic [63:0] d1, input logic [7:0] m1, input logic push);
    if (push) wq.push_back({d1, m1, d0, m0});
    wr_beat(d0, m0);
    wr_beat(d1, m1);
  endtask

  task automatic cmd_issue(input logic [2:0] b, input logic [15:0] a, input logic push);
    bank = b; addr = a; cs_n = 1'b0;
    if (push) cq.push_back(exp_cmd(b, a));
    cyc();
    cs_n = 1'b1;
  endtask

  task automatic rd_burst(input logic v, input logic [127:0] data,
                          input logic [63:0] e0, input logic [63:0] e1);
    rd_v = v; rd_data = data;
    rq.push_back('{d: e0, y: 1'b0});
    rq.push_back('{d: e1, y: v});
    rd_en = 1'b1;
    cyc(); cyc();
    rd_en = 1'b0;
    repeat (LAT + 1) cyc();
  endtask

  task automatic check_idle(input string name);
    check({name, "_wr_v"},  256'(fifo_wr_v_o), 256'(0));
    check({name, "_wr_d"},  256'(fifo_wr_data_o), 256'(0));
    check({name, "_cmd_v"}, 256'(fifo_cmd_v_o), 256'(0));
    check({name, "_rd_vl"}, 256'(dfi_rddata_valid_o), 256'(0));
    check({name, "_rd_d"},  256'(dfi_rddata_o), 256'(0));
    check({name, "_yumi"},  256'(fifo_rd_yumi_o), 256'(0));
    check({name, "_err"},   256'(fifo_error_o), 256'(0));
  endtask

  // Scoreboard: pop expected items as the DUT hands them over
  always @(negedge clk) begin
    if (!reset_i) begin
      if (fifo_wr_v_o && wr_ready) begin
        if (wq.size() == 0) check("wr_unexpected", 256'(fifo_wr_data_o), 256'(0) - 1);
        else check("wr_word", 256'(fifo_wr_data_o), 256'(wq.pop_front()));
      end
      if (fifo_cmd_v_o && cmd_ready) begin
        if (cq.size() == 0) check("cmd_unexpected", 256'(fifo_cmd_data_o), 256'(0) - 1);
        else check("cmd_word", 256'(fifo_cmd_data_o), 256'(cq.pop_front()));
      end
      if (dfi_rddata_valid_o) begin
        if (rq.size() == 0) begin
          check("rd_unexpected", 256'(dfi_rddata_valid_o), 256'(0));
        end else begin
          rd_exp_t e;
          e = rq.pop_front();
          check("rd_beat", 256'(dfi_rddata_o), 256'(e.d));
          check("rd_yumi", 256'(fifo_rd_yumi_o), 256'(e.y));
        end
      end else begin
        check("rd_idle", 256'({dfi_rddata_o, fifo_rd_yumi_o}), 256'(0));
      end
    end
  end

  wr_vec_t wv [3];
  rd_vec_t rv [3];

  initial begin
    wv[0] = '{64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 64'hBBBB_BBBB_BBBB_BBBB, 8'h0F,
              {64'hBBBB_BBBB_BBBB_BBBB, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00}};
    wv[1] = '{64'h0123_4567_89AB_CDEF, 8'hA5, 64'hFEDC_BA98_7654_3210, 8'h3C,
              {64'hFEDC_BA98_7654_3210, 8'h3C, 64'h0123_4567_89AB_CDEF, 8'hA5}};
    wv[2] = '{64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00,
              {64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 8'hFF}};
    rv[0] = '{{64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    rv[1] = '{128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98,
              64'h89AB_CDEF_FEDC_BA98, 64'hDEAD_BEEF_0123_4567};
    rv[2] = '{{64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    // Reset state
    cyc(); cyc();
    @(negedge clk);
    check_idle("reset");
    cyc();
    reset_i = 1'b0;
    cyc();

    // Write packing table, downstream always ready
    for (int i = 0; i < 3; i++) begin
      wq.push_back(wv[i].exp);
      wr_beat(wv[i].d0, wv[i].m0);
      wr_beat(wv[i].d1, wv[i].m1);
      repeat (2) cyc();
    end
    check("pack_drained", 256'(wq.size()), 256'(0));
    check("pack_err", 256'(fifo_error_o), 256'(0));

    // Write overflow: 5 bursts into a 4-deep FIFO, the 5th is dropped
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_burst(64'h1000_0000_0000_0000 | 64'(i), 8'(i), 64'h2000_0000_0000_0000 | 64'(i),
               8'(8'hF0 | 8'(i)), i < 4);
    end
    @(negedge clk);
    check("wovf_err", 256'(fifo_error_o), 256'(3'b001));
    check("wovf_v", 256'(fifo_wr_v_o), 256'(1));
    check("wovf_held", 256'(wq.size()), 256'(4));
    wr_ready = 1'b1;
    repeat (6) cyc();
    check("wovf_drained", 256'(wq.size()), 256'(0));
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    @(negedge clk);
    check("wovf_clear", 256'(fifo_error_o), 256'(0));

    // Commands, ready then stalled
    for (int i = 1; i <= 3; i++) cmd_issue(3'(i + 4), 16'(i), 1'b1);
    repeat (3) cyc();
    check("cmd_drained", 256'(cq.size()), 256'(0));
    check("cmd_err0", 256'(fifo_error_o), 256'(0));
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) cmd_issue(3'(i), 16'(16'h0100 + i), i < 4);
    @(negedge clk);
    check("covf_err", 256'(fifo_error_o), 256'(3'b010));
    cmd_ready = 1'b1;
    repeat (6) cyc();
    check("covf_drained", 256'(cq.size()), 256'(0));
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // Read unpack table
    for (int i = 0; i < 3; i++) rd_burst(1'b1, rv[i].data, rv[i].e0, rv[i].e1);
    check("rd_drained", 256'(rq.size()), 256'(0));
    check("rd_err0", 256'(fifo_error_o), 256'(0));

    // Underrun, then clear
    rd_burst(1'b0, '0, 64'h0, 64'h0);
    @(negedge clk);
    check("urun_err", 256'(fifo_error_o), 256'(3'b100));
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    @(negedge clk);
    check("urun_clear", 256'(fifo_error_o), 256'(0));

    // Clear held across an underrun burst: new errors win while beats arrive
    err_clr = 1'b1; rd_v = 1'b0;
    rq.push_back('{d: 64'h0, y: 1'b0});
    rq.push_back('{d: 64'h0, y: 1'b0});
    rd_en = 1'b1; cyc(); cyc(); rd_en = 1'b0;
    cyc();
    @(negedge clk);
    check("clr_vs_err1", 256'(fifo_error_o), 256'(3'b100));
    cyc();
    @(negedge clk);
    check("clr_vs_err2", 256'(fifo_error_o), 256'(3'b100));
    cyc();
    @(negedge clk);
    check("clr_after", 256'(fifo_error_o), 256'(0));
    err_clr = 1'b0;

    // Reset mid-operation: buffered word, command, half burst, read in flight
    wr_ready = 1'b0; cmd_ready = 1'b0;
    wr_burst(64'hDEAD_DEAD_DEAD_DEAD, 8'h11, 64'hBEEF_BEEF_BEEF_BEEF, 8'h22, 1'b0);
    cmd_issue(3'd7, 16'hFFFF, 1'b0);
    rd_v = 1'b1; rd_data = '1; rd_en = 1'b1;
    wr_beat(64'h5555_5555_5555_5555, 8'h55);
    rd_en = 1'b0;
    reset_i = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    check_idle("midrst");
    reset_i = 1'b0; wr_ready = 1'b1; cmd_ready = 1'b1; rd_v = 1'b0;
    cyc();
    wr_burst(64'h7777_7777_7777_7777, 8'h07, 64'h8888_8888_8888_8888, 8'h08, 1'b1);
    repeat (4) cyc();
    check("rst_wr_drained", 256'(wq.size()), 256'(0));
    check("rst_cmd_q", 256'(cq.size()), 256'(0));
    check("rst_rd_q", 256'(rq.size()), 256'(0));
    check("rst_err", 256'(fifo_error_o), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_dfi_to_fifo_packer.md
Name: bsg_dfi_to_fifo_packer

Overview:
Single-clock DFI-to-FIFO bridge for the DRAM controller side of the DMC path.
- Packs clk_ratio_p consecutive DFI write beats into one wide FIFO word.
- Buffers commands and packed write words in parameterised-depth FIFOs.
- Unpacks wide read words back into per-cycle DFI read beats, with a programmable read latency.
- Reports per-path overflow and underrun errors as sticky flags.

Parameters:
dq_data_width_p, 32, DQ width per DFI phase; must be a multiple of 8; dq_group_lp = dq_data_width_p/8.
clk_ratio_p, 2, DFI beats per packed word; legal values 1..8.
els_p, 4, depth of the write FIFO and the command FIFO; power of 2, >= 2.
rd_latency_p, 2, cycles from dfi_rddata_en_i to dfi_rddata_valid_o; legal values 1..8.
Derived:
- beat_w_lp = 2*dq_data_width_p + 2*dq_group_lp
- word_w_lp = clk_ratio_p*beat_w_lp
- rword_w_lp = clk_ratio_p*2*dq_data_width_p
- cmd_w_lp = 26

Ports:
clk_i  in  1  single clock shared by the DFI side and the FIFO side.
reset_i  in  1  synchronous, active-high reset.
dfi_bank_i  in  3  bank address.
dfi_address_i  in  16  row/column address.
dfi_cke_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i, dfi_reset_n_i, dfi_odt_i  in  1 each  DFI control signals.
dfi_wrdata_en_i  in  1  write beat valid.
dfi_wrdata_i  in  2*dq_data_width_p  write data beat.
dfi_wrdata_mask_i  in  2*dq_group_lp  write mask beat.
dfi_rddata_en_i  in  1  read beat request.
dfi_rddata_o  out  2*dq_data_width_p  read data beat.
dfi_rddata_valid_o  out  1  read beat valid.
fifo_wr_v_o  out  1  packed write word valid.
fifo_wr_data_o  out  word_w_lp  packed write word.
fifo_wr_ready_i  in  1  downstream ready for write words.
fifo_cmd_v_o  out  1  command valid.
fifo_cmd_data_o  out  26  {bank, address, cke, cs_n, ras_n, cas_n, we_n, reset_n, odt}.
fifo_cmd_ready_i  in  1  downstream ready for commands.
fifo_rd_v_i  in  1  wide read word available.
fifo_rd_data_i  in  rword_w_lp  wide read word.
fifo_rd_yumi_o  out  1  consumes the current read word.
error_clear_i  in  1  clears all sticky error bits.
fifo_error_o  out  3  sticky errors: [0] write overflow, [1] command overflow, [2] read underrun.

Behaviour:
- Reset values: all valid/yumi outputs 0, fifo_error_o 3'b000, dfi_rddata_o 0. All counters 0, both FIFOs empty, read-latency pipeline cleared.
- Reset mid-operation discards any partially packed write word, all FIFO contents, and any in-flight read beats.
- Write packer:
  - Counter wr_cnt runs 0..clk_ratio_p-1 and advances on each dfi_wrdata_en_i cycle.
  - Beat k = {dfi_wrdata_i, dfi_wrdata_mask_i} is stored at bits [k*beat_w_lp +: beat_w_lp]; beat 0 occupies the LSBs.
  - On the beat where wr_cnt == clk_ratio_p-1, the word {current beat, stored beats} is enqueued that same cycle and wr_cnt wraps to 0.
  - clk_ratio_p == 1: every beat is enqueued directly.
- Command path: every cycle with dfi_cs_n_i == 0 enqueues one command into the command FIFO.
- FIFOs:
  - Both are els_p-deep, first-in first-out, with one cycle from enqueue to v_o.
  - Dequeue occurs on v_o & ready_i.
  - Full is evaluated before the same-cycle dequeue: an enqueue while full is dropped even if a dequeue happens that cycle.
  - A dropped write word sets fifo_error_o[0]; a dropped command sets fifo_error_o[1]. wr_cnt still wraps.
  - Simultaneous enqueue and dequeue when not full leaves the occupancy unchanged.
- Read path:
  - dfi_rddata_en_i passes through an rd_latency_p-stage resettable shift register; its output is dfi_rddata_valid_o.
  - Counter rd_cnt advances on each valid cycle and wraps at clk_ratio_p-1.
  - While valid and fifo_rd_v_i == 1: dfi_rddata_o = fifo_rd_data_i[rd_cnt*2*dq_data_width_p +: 2*dq_data_width_p]. Beat 0 comes from the LSBs.
  - While valid and fifo_rd_v_i == 0: dfi_rddata_o = 0, fifo_error_o[2] is set, and rd_cnt still advances.
  - When not valid: dfi_rddata_o = 0.
  - fifo_rd_yumi_o = valid & fifo_rd_v_i & (rd_cnt == clk_ratio_p-1). It is combinational from registered state.
- Errors:
  - Error bits are sticky until reset_i or error_clear_i.
  - When a clear and a new error occur in the same cycle, the error wins: the bit reads 1 the next cycle.

Test Plan:
1. Write packing: dq=32, ratio=2; drive beat0 data=0xA..., mask=0x0, then beat1 data=0xB..., mask=0xF -> one cycle later fifo_wr_v_o=1 with beat0 in the LSBs and beat1 in the MSBs; exactly one word is produced.
2. Write overflow: els_p=4, fifo_wr_ready_i=0, 5 complete bursts -> 4 words buffered, fifo_error_o=3'b001; then raise ready -> the 4 words drain in order.
3. Commands: cs_n low for 3 cycles with addresses 1,2,3 and ready=1 -> fifo_cmd_v_o on 3 consecutive cycles with addresses 1,2,3, no error. Repeat with ready=0 and 5 commands -> fifo_error_o[1]=1.
4. Read latency/unpack: rd_latency_p=2, ratio=2, fifo_rd_v_i=1, data={0x2222…,0x1111…}, rddata_en high for 2 cycles -> valid high 2 cycles later, outputs 0x1111… then 0x2222…, yumi=1 on the second beat only.
5. Underrun: rddata_en for one burst with fifo_rd_v_i=0 -> dfi_rddata_o=0, fifo_error_o[2]=1, no yumi. Pulse error_clear_i -> error reads 0 the next cycle.
6. Reset mid-burst: one write beat of a ratio-2 burst, then reset_i, then a full burst -> exactly one word, containing only the post-reset beats; all outputs 0 during reset.
